// File: rtl/cdb_issue_arbiter.sv
// CDB issue scheduler: reserves future CDB slots per latency class,
// round-robins int/ls and interlocks the non-pipelined divider.
module cdb_issue_arbiter #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_ready,
    output logic       int_issue,
    input  logic       ls_ready,
    output logic       ls_issue,
    input  logic       mult_ready,
    output logic       mult_issue,
    input  logic       div_ready,
    output logic       div_issue,
    output logic       div_busy,
    output logic       cdb_sel_valid,
    output logic [1:0] cdb_sel
);

    localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

    localparam logic [1:0] SRC_INT  = 2'd0;
    localparam logic [1:0] SRC_LS   = 2'd1;
    localparam logic [1:0] SRC_MULT = 2'd2;
    localparam logic [1:0] SRC_DIV  = 2'd3;

    logic [DIV_LAT-1:1]      rsv;
    logic [DIV_LAT-1:1]      rsv_nxt;
    logic [DIV_LAT-1:1][1:0] own;
    logic [DIV_LAT-1:1][1:0] own_nxt;
    logic [CW-1:0]           div_cnt;
    logic                    rr;
    logic                    slot1_free;
    logic [1:0]              sel_nxt;

    // rr=0 prefers int, rr=1 prefers ls when both contend for slot 1
    always_comb begin
        slot1_free = !rsv[1];
        div_issue  = !rst && div_ready && (div_cnt == '0);
        mult_issue = !rst && mult_ready && !rsv[MULT_LAT];
        int_issue  = !rst && slot1_free && int_ready
                     && (!ls_ready || !rr);
        ls_issue   = !rst && slot1_free && ls_ready
                     && (!int_ready || rr);
    end

    assign div_busy = (div_cnt != '0);

    always_comb begin
        rsv_nxt = '0;
        own_nxt = '0;
        for (int k = 1; k < DIV_LAT - 1; k++) begin
            rsv_nxt[k] = rsv[k+1];
            own_nxt[k] = own[k+1];
        end
        if (mult_issue) begin
            rsv_nxt[MULT_LAT-1] = 1'b1;
            own_nxt[MULT_LAT-1] = SRC_MULT;
        end
        rsv_nxt[DIV_LAT-1] = div_issue;
        own_nxt[DIV_LAT-1] = div_issue ? SRC_DIV : SRC_INT;
    end

    always_comb begin
        sel_nxt = SRC_INT;
        if (rsv[1]) begin
            sel_nxt = own[1];
        end else if (ls_issue) begin
            sel_nxt = SRC_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsv           <= '0;
            own           <= '0;
            div_cnt       <= '0;
            rr            <= 1'b0;
            cdb_sel_valid <= 1'b0;
            cdb_sel       <= SRC_INT;
        end else begin
            rsv           <= rsv_nxt;
            own           <= own_nxt;
            cdb_sel_valid <= rsv[1] | int_issue | ls_issue;
            cdb_sel       <= sel_nxt;
            if (div_issue) begin
                div_cnt <= CW'(DIV_LAT - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
            if (int_issue) begin
                rr <= 1'b1;
            end else if (ls_issue) begin
                rr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_issue_arbiter.sv
// Bench for cdb_issue_arbiter: directed table plus random traffic
// checked against an absolute-time CDB calendar model.
module tb_cdb_issue_arbiter;

    localparam int ML = 4;
    localparam int DL = 7;
    localparam int NCAL = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_ready, ls_ready, mult_ready, div_ready;
    logic       int_issue, ls_issue, mult_issue, div_issue;
    logic       div_busy, cdb_sel_valid;
    logic [1:0] cdb_sel;

    int checks = 0;
    int errors = 0;

    cdb_issue_arbiter #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk          (clk),
        .rst          (rst),
        .int_ready    (int_ready),
        .int_issue    (int_issue),
        .ls_ready     (ls_ready),
        .ls_issue     (ls_issue),
        .mult_ready   (mult_ready),
        .mult_issue   (mult_issue),
        .div_ready    (div_ready),
        .div_issue    (div_issue),
        .div_busy     (div_busy),
        .cdb_sel_valid(cdb_sel_valid),
        .cdb_sel      (cdb_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r, ck, ir, lr, mr, dr;
        bit       ei, el, em, ed, eb, ev;
        bit [1:0] es;
    } vec_t;

    vec_t tab[$];

    // model: calendar of expected CDB owners by absolute cycle
    bit       mv[NCAL];
    bit [1:0] mo[NCAL];
    bit       dv[NCAL];
    int       div_next;
    bit       rr_m;
    int       cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit ck, bit ir, bit lr,
                                bit mr, bit dr, bit ei, bit el,
                                bit em, bit ed, bit eb, bit ev,
                                bit [1:0] es);
        vec_t v;
        v.r = r; v.ck = ck; v.ir = ir; v.lr = lr;
        v.mr = mr; v.dr = dr; v.ei = ei; v.el = el;
        v.em = em; v.ed = ed; v.eb = eb; v.ev = ev;
        v.es = es;
        return v;
    endfunction

    function automatic vec_t rst_row();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t idle(bit eb, bit ev, bit [1:0] es);
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, eb, ev, es);
    endfunction

    task automatic dut_grant(input bit g, input int lat);
        if (g) begin
            chk("cdb_collision", int'(dv[cyc+lat]), 0);
            dv[cyc+lat] = 1'b1;
        end
    endtask

    task automatic step(input vec_t v, input bit use_tab);
        bit xi, xl, xm, xd, fr;
        rst        = v.r;
        int_ready  = v.ir;
        ls_ready   = v.lr;
        mult_ready = v.mr;
        div_ready  = v.dr;
        @(negedge clk);
        xd = !v.r && v.dr && (cyc >= div_next);
        xm = !v.r && v.mr && !mv[cyc+ML];
        fr = !v.r && !mv[cyc+1];
        xi = fr && v.ir && (!v.lr || !rr_m);
        xl = fr && v.lr && (!v.ir || rr_m);
        chk("m_int_issue", int'(int_issue), int'(xi));
        chk("m_ls_issue", int'(ls_issue), int'(xl));
        chk("m_mult_issue", int'(mult_issue), int'(xm));
        chk("m_div_issue", int'(div_issue), int'(xd));
        chk("m_div_busy", int'(div_busy), int'(div_next > cyc));
        chk("m_cdb_valid", int'(cdb_sel_valid), int'(mv[cyc]));
        if (mv[cyc]) chk("m_cdb_sel", int'(cdb_sel), int'(mo[cyc]));
        if (use_tab) begin
            chk("t_int_issue", int'(int_issue), int'(v.ei));
            chk("t_ls_issue", int'(ls_issue), int'(v.el));
            chk("t_mult_issue", int'(mult_issue), int'(v.em));
            chk("t_div_issue", int'(div_issue), int'(v.ed));
            if (v.ck) begin
                chk("t_div_busy", int'(div_busy), int'(v.eb));
                chk("t_cdb_valid", int'(cdb_sel_valid), int'(v.ev));
                if (v.ev) chk("t_cdb_sel", int'(cdb_sel), int'(v.es));
            end
        end
        dut_grant(int_issue | ls_issue, 1);
        dut_grant(mult_issue, ML);
        dut_grant(div_issue, DL);
        if (v.r) begin
            for (int k = cyc + 1; k <= cyc + DL; k++) begin
                mv[k] = 1'b0;
                dv[k] = 1'b0;
            end
            div_next = 0;
            rr_m = 1'b0;
        end else begin
            if (xd) begin
                mv[cyc+DL] = 1'b1; mo[cyc+DL] = 2'd3;
                div_next = cyc + DL;
            end
            if (xm) begin
                mv[cyc+ML] = 1'b1; mo[cyc+ML] = 2'd2;
            end
            if (xi) begin
                mv[cyc+1] = 1'b1; mo[cyc+1] = 2'd0; rr_m = 1'b1;
            end
            if (xl) begin
                mv[cyc+1] = 1'b1; mo[cyc+1] = 2'd1; rr_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1;
        int_ready = 1'b1; ls_ready = 1'b1;
        mult_ready = 1'b1; div_ready = 1'b1;
        cyc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_int_issue", int'(int_issue), 0);
        chk("rst_ls_issue", int'(ls_issue), 0);
        chk("rst_mult_issue", int'(mult_issue), 0);
        chk("rst_div_issue", int'(div_issue), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        int_ready = 1'b0; ls_ready = 1'b0;
        mult_ready = 1'b0; div_ready = 1'b0;
        @(negedge clk);
        chk("rst_cdb_valid", int'(cdb_sel_valid), 0);
        chk("rst_cdb_sel", int'(cdb_sel), 0);
        chk("rst_div_busy", int'(div_busy), 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < NCAL; k++) begin
            mv[k] = 1'b0; mo[k] = 2'd0; dv[k] = 1'b0;
        end
        div_next = 0;
        rr_m = 1'b0;

        // int back-to-back
        tab.push_back(rst_row());
        tab.push_back(mk(0,1,1,0,0,0,1,0,0,0,0,0,0));
        tab.push_back(mk(0,1,1,0,0,0,1,0,0,0,0,1,0));
        tab.push_back(mk(0,1,1,0,0,0,1,0,0,0,0,1,0));
        tab.push_back(idle(0,1,0));
        tab.push_back(idle(0,0,0));
        // int/ls alternate
        tab.push_back(rst_row());
        tab.push_back(mk(0,1,1,1,0,0,1,0,0,0,0,0,0));
        tab.push_back(mk(0,1,1,1,0,0,0,1,0,0,0,1,0));
        tab.push_back(mk(0,1,1,1,0,0,1,0,0,0,0,1,1));
        tab.push_back(mk(0,1,1,1,0,0,0,1,0,0,0,1,0));
        tab.push_back(idle(0,1,1));
        tab.push_back(idle(0,0,0));
        // mult blocks slot 1 at t=3
        tab.push_back(rst_row());
        tab.push_back(mk(0,1,0,0,1,0,0,0,1,0,0,0,0));
        tab.push_back(idle(0,0,0));
        tab.push_back(idle(0,0,0));
        tab.push_back(mk(0,1,1,1,0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(0,1,1,1,0,0,1,0,0,0,0,1,2));
        tab.push_back(idle(0,1,0));
        tab.push_back(idle(0,0,0));
        // divider interlock
        tab.push_back(rst_row());
        tab.push_back(mk(0,1,0,0,0,1,0,0,0,1,0,0,0));
        for (int i = 0; i < 6; i++)
            tab.push_back(mk(0,1,0,0,0,1,0,0,0,0,1,0,0));
        tab.push_back(mk(0,1,0,0,0,1,0,0,0,1,0,1,3));
        for (int i = 0; i < 6; i++)
            tab.push_back(mk(0,1,0,0,0,1,0,0,0,0,1,0,0));
        tab.push_back(mk(0,1,0,0,0,1,0,0,0,1,0,1,3));
        tab.push_back(idle(1,0,0));
        // div reservation blocks mult
        tab.push_back(rst_row());
        tab.push_back(mk(0,1,0,0,0,1,0,0,0,1,0,0,0));
        tab.push_back(idle(1,0,0));
        tab.push_back(idle(1,0,0));
        tab.push_back(mk(0,1,0,0,1,0,0,0,0,0,1,0,0));
        tab.push_back(mk(0,1,0,0,1,0,0,0,1,0,1,0,0));
        tab.push_back(idle(1,0,0));
        tab.push_back(idle(1,0,0));
        tab.push_back(idle(0,1,3));
        tab.push_back(idle(0,1,2));
        tab.push_back(idle(0,0,0));
        // reset discards reservations
        tab.push_back(rst_row());
        tab.push_back(mk(0,1,0,0,1,1,0,0,1,1,0,0,0));
        tab.push_back(idle(1,0,0));
        tab.push_back(mk(1,1,0,0,0,0,0,0,0,0,1,0,0));
        tab.push_back(idle(0,0,0));
        tab.push_back(mk(0,1,1,1,0,0,1,0,0,0,0,0,0));
        tab.push_back(idle(0,1,0));
        for (int i = 0; i < 4; i++) tab.push_back(idle(0,0,0));

        foreach (tab[i]) step(tab[i], 1'b1);

        for (int i = 0; i < 3000; i++) begin
            rv = rst_row();
            rv.r  = ($urandom_range(0, 79) == 0);
            rv.ir = ($urandom_range(0, 99) < 55);
            rv.lr = ($urandom_range(0, 99) < 55);
            rv.mr = ($urandom_range(0, 99) < 40);
            rv.dr = ($urandom_range(0, 99) < 30);
            step(rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_issue_arbiter.md
# cdb_issue_arbiter

Issue scheduler for the out-of-order core, placed between the four execution queues (integer, load/store, multiply, divide) and their functional units. It decides each cycle which queues may issue, so that no two results ever collide on the common data bus (CDB). It also drives the registered CDB source select used by the CDB mux. It tracks future CDB occupancy with a per-slot reservation shift register, arbitrates the two single-cycle units round-robin, and interlocks the non-pipelined divider.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- `MULT_LAT`, default 4: multiplier issue-to-CDB latency in cycles. Pipelined unit.
- `DIV_LAT`, default 7: divider issue-to-CDB latency in cycles. Non-pipelined unit.
- Legal range: 2 ≤ MULT_LAT < DIV_LAT ≤ 16.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `int_ready`  in  1  integer queue holds an issuable instruction.
- `int_issue`  out  1  grant; integer queue issues this cycle (latency 1).
- `ls_ready`  in  1  load/store queue holds an issuable instruction.
- `ls_issue`  out  1  grant; load/store queue issues this cycle (latency 1).
- `mult_ready`  in  1  multiply queue holds an issuable instruction.
- `mult_issue`  out  1  grant; multiply issues this cycle (latency MULT_LAT).
- `div_ready`  in  1  divide queue holds an issuable instruction.
- `div_issue`  out  1  grant; divide issues this cycle (latency DIV_LAT).
- `div_busy`  out  1  divider occupied; no divide may issue.
- `cdb_sel_valid`  out  1  registered; a functional unit drives the CDB this cycle.
- `cdb_sel`  out  2  registered CDB owner: 0=int, 1=ls, 2=mult, 3=div.

## Operation
State:
- Reservation vector `rsv[k]`, k=1..DIV_LAT-1. A set bit means the CDB is taken k cycles from now. Each slot carries a 2-bit owner.
- Divider down-counter `div_cnt`, width ceil(log2(DIV_LAT)).
- Round-robin bit `rr`: 0 prefers int, 1 prefers ls.

Grant rules are combinational from the `*_ready` inputs and registered state:
- `div_issue` = div_ready & (div_cnt==0). The slot at DIV_LAT is always free by construction.
- `mult_issue` = mult_ready & !rsv[MULT_LAT].
- int and ls both require !rsv[1].
  - If only one of them is ready, that one is granted.
  - If both are ready, the unit preferred by `rr` is granted and the other is not.
- Grants to different latencies are independent, so up to three grants can occur in one cycle (div, mult, one of int/ls).

Updates each cycle (when not in reset):
- Shift: rsv'[k] = rsv[k+1] | (grant with latency k+1), for k < DIV_LAT-1.
- Top slot: rsv'[DIV_LAT-1] = div_issue-independent term 0 | (grant with latency DIV_LAT).
- Owners shift alongside the valid bits. The newly set slot takes the grantee's code.
- cdb_sel_valid' = rsv[1] | int_issue | ls_issue. cdb_sel' = owner of rsv[1], or 0/1 for an int/ls grant.
- A single-cycle grant and rsv[1] are mutually exclusive by rule.
- On div_issue, div_cnt' = DIV_LAT-1. Otherwise it decrements while nonzero.
- div_busy = (div_cnt != 0).
- On any int/ls grant, `rr` is set to point at the non-granted unit. With no int/ls grant, `rr` holds.

Reset:
- rsv, owners, div_cnt, rr, cdb_sel_valid and cdb_sel clear to 0.
- All `*_issue` outputs are forced to 0 while rst=1.
- Reset mid-operation discards every reservation. The team's flush sequence resets the functional units in the same cycle.

The block has no flush input. Branch recovery is handled by the queues and does not cancel reservations for instructions already issued.

## Timing
- Grant latency is 0: `*_issue` is valid in the same cycle as `*_ready`, and the queue removes the entry on the clock edge where issue=1.
- A grant at cycle t produces cdb_sel_valid=1, with the grantee's code on cdb_sel, at exactly t+L (L = 1, MULT_LAT or DIV_LAT).
- Divides are at least DIV_LAT cycles apart. div_busy is high for cycles t+1..t+DIV_LAT-1 after a divide at t.
- A divide may issue in the same cycle its previous result drives the CDB.
- At most one result reaches the CDB per cycle. This is an invariant the verification engineer must assert every cycle.

## Test plan
- Reset, then int_ready=1 for cycles 0..2 with other inputs low: int_issue=1 in cycles 0..2, and cdb_sel_valid=1 with cdb_sel=0 in cycles 1..3.
- int_ready and ls_ready both held high for 4 cycles: grants go int, ls, int, ls; cdb_sel reads 0,1,0,1 in cycles 1..4.
- mult_ready pulsed at t=0 (granted), then int_ready and ls_ready high at t=3: both denied at t=3 and granted at t=4. cdb_sel=2 at t=4, then int/ls at t=5.
- div_ready held high from t=0: div_issue at t=0, 7 and 14; div_busy=1 for t=1..6; cdb_sel=3 at t=7 and t=14.
- div granted at t=0, mult_ready high from t=3: mult denied at t=3 (slot t+7 is taken) and granted at t=4; cdb_sel is 3 at t=7 and 2 at t=8.
- Mult and div issued, then rst for one cycle at t=2: at t=3 cdb_sel_valid=0, div_busy=0, rr=int, and no stale CDB selection appears afterwards.
